// File: rtl/seq_div_18bits.sv
// Unsigned iterative restoring divider: one quotient bit per cycle from a
// ripple-borrow trial subtraction, valid/ready on both ends, one op in flight.
module seq_div_18bits #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             dbz_q, dbz_d;

    // The partial remainder is always below the divisor, so its top bit is
    // constant zero and only WIDTH bits are stored.
    logic [WIDTH:0]   shift_a;
    logic [WIDTH:0]   brw;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    assign shift_a = {r_q, q_q[WIDTH-1]};
    assign brw[0]  = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sub
            assign diff[gi]    = shift_a[gi] ^ dsr_q[gi] ^ brw[gi];
            assign brw[gi+1]   = (~shift_a[gi] & dsr_q[gi])
                               | (~(shift_a[gi] ^ dsr_q[gi]) & brw[gi]);
        end
    endgenerate

    // Top subtrahend bit is zero, so the final borrow stage collapses.
    assign borrow_out = ~shift_a[WIDTH] & brw[WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dsr_d   = dsr_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dsr_d = divisor;
                    if (divisor == '0) begin
                        q_d     = '1;
                        r_d     = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        q_d     = dividend;
                        r_d     = '0;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                q_d = {q_q[WIDTH-2:0], ~borrow_out};
                r_d = borrow_out ? shift_a[WIDTH-1:0] : diff;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    dbz_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dsr_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dsr_q   <= dsr_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = q_q;
    assign remainder   = r_q;
    assign div_by_zero = dbz_q;
endmodule
